// File: rtl/vram_arbiter_if.sv
// Signal bundle between the raster adapter, the Z80 bus, the VRAM and vram_arbiter.
interface vram_arbiter_if;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] vid_data;
    logic              vid_ack;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        output vid_data, vid_ack, cpu_rdata, cpu_ready, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        input  vid_data, vid_ack, cpu_rdata, cpu_ready, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// Shares the single-port VRAM between video fetch and Z80 access through a 3-stage pipeline.
// Define VRAM_CPU_ANTISTARVE_EN to let a starved CPU access jump ahead of one video fetch.
module vram_arbiter #(
    parameter int unsigned MAX_CPU_WAIT = 8
) (
    input  logic           CLOCK,
    input  logic           RESET,
    vram_arbiter_if.slave  bus
);
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {T_NONE, T_VID, T_CPU} tag_t;
    typedef enum logic [1:0] {C_IDLE, C_ISSUED, C_DONE} cpu_state_t;

    if (MAX_CPU_WAIT < 1) begin : g_param_check
        $error("MAX_CPU_WAIT must be at least 1");
    end

    tag_t              tag_q1, tag_q2, tag_d;
    logic              we_q2;
    cpu_state_t        cpu_state, cpu_state_d;
    logic              cpu_elig;
    logic              cpu_grant;
    logic [ADDR_W-1:0] mem_addr_d;
    logic              mem_we_d;
    logic [DATA_W-1:0] mem_wdata_d;

    assign cpu_elig = (cpu_state == C_IDLE) && bus.cpu_req;

`ifdef VRAM_CPU_ANTISTARVE_EN
    localparam int unsigned CNT_W = $clog2(MAX_CPU_WAIT + 1);

    logic [CNT_W-1:0]  wait_cnt, wait_cnt_d;
    logic              pend_v, pend_v_d;
    logic [ADDR_W-1:0] pend_addr, pend_addr_d;
    logic              starve;

    assign starve = (wait_cnt >= CNT_W'(MAX_CPU_WAIT));

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            wait_cnt  <= '0;
            pend_v    <= 1'b0;
            pend_addr <= '0;
        end else begin
            wait_cnt  <= wait_cnt_d;
            pend_v    <= pend_v_d;
            pend_addr <= pend_addr_d;
        end
    end
`endif

    // Slot grant, issue-stage payload and CPU port next state
    always_comb begin
        tag_d       = T_NONE;
        cpu_grant   = 1'b0;
        mem_addr_d  = bus.mem_addr;
        mem_we_d    = 1'b0;
        mem_wdata_d = bus.mem_wdata;
        cpu_state_d = cpu_state;
`ifdef VRAM_CPU_ANTISTARVE_EN
        wait_cnt_d  = wait_cnt;
        pend_v_d    = pend_v;
        pend_addr_d = pend_addr;

        if (pend_v) begin
            tag_d       = T_VID;
            mem_addr_d  = pend_addr;
            pend_v_d    = bus.vid_req;
            pend_addr_d = bus.vid_addr;
        end else if (bus.vid_req && !(starve && cpu_elig)) begin
            tag_d      = T_VID;
            mem_addr_d = bus.vid_addr;
        end else if (cpu_elig) begin
            cpu_grant = 1'b1;
            if (bus.vid_req) begin
                pend_v_d    = 1'b1;
                pend_addr_d = bus.vid_addr;
            end
        end

        if (cpu_grant) begin
            wait_cnt_d = '0;
        end else if (cpu_elig && (wait_cnt < CNT_W'(MAX_CPU_WAIT))) begin
            wait_cnt_d = wait_cnt + CNT_W'(1);
        end
`else
        if (bus.vid_req) begin
            tag_d      = T_VID;
            mem_addr_d = bus.vid_addr;
        end else if (cpu_elig) begin
            cpu_grant = 1'b1;
        end
`endif
        if (cpu_grant) begin
            tag_d      = T_CPU;
            mem_addr_d = bus.cpu_addr;
            mem_we_d   = bus.cpu_we;
            if (bus.cpu_we) begin
                mem_wdata_d = bus.cpu_wdata;
            end
        end

        case (cpu_state)
            C_IDLE:   if (cpu_grant) cpu_state_d = C_ISSUED;
            C_ISSUED: if (tag_q2 == T_CPU) cpu_state_d = C_DONE;
            C_DONE:   cpu_state_d = C_IDLE;
            default:  cpu_state_d = C_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            cpu_state     <= C_IDLE;
            tag_q1        <= T_NONE;
            tag_q2        <= T_NONE;
            we_q2         <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_wdata <= '0;
            bus.vid_data  <= '0;
            bus.vid_ack   <= 1'b0;
            bus.cpu_rdata <= '0;
            bus.cpu_ready <= 1'b0;
        end else begin
            cpu_state     <= cpu_state_d;
            tag_q1        <= tag_d;
            tag_q2        <= tag_q1;
            we_q2         <= bus.mem_we;
            bus.mem_addr  <= mem_addr_d;
            bus.mem_we    <= mem_we_d;
            bus.mem_wdata <= mem_wdata_d;
            bus.vid_ack   <= (tag_q2 == T_VID);
            bus.cpu_ready <= (tag_q2 == T_CPU);
            if (tag_q2 == T_VID) begin
                bus.vid_data <= bus.mem_rdata;
            end
            // Writes complete with a ready pulse but leave the last read byte in place
            if ((tag_q2 == T_CPU) && !we_q2) begin
                bus.cpu_rdata <= bus.mem_rdata;
            end
        end
    end
endmodule
